// File: rtl/mc_state_seq.sv
// mc_state_seq: next-state sequencer for the multi-cycle MIPS datapath.
// Produces the 4-bit state code consumed by the state-to-control decoder.
// Adds an IDLE state (10) so the core can halt between instructions, with
// run (free-running) and step (single instruction) controls.
// Optional feature: define MC_PERF_CNT_EN to build the cycle_cnt/instr_cnt
// performance counters; otherwise both ports are tied to zero.
module mc_state_seq #(
    parameter int          CNT_W    = 32,
    parameter logic [5:0]  OP_RTYPE = 6'h00,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B,
    parameter logic [5:0]  OP_BEQ   = 6'h04,
    parameter logic [5:0]  OP_J     = 6'h02
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             run,
    input  logic             step,
    output logic [3:0]       current_state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IDLE   = 4'd10
    } state_t;

    state_t state_q, state_d;
    logic   done_q, done_d;
    logic   illegal_q, illegal_d;

    // Terminal states end an instruction; the following cycle pulses instr_done.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = S_IDLE;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!illegal_q && (run || step)) state_d = S_FETCH;
                else                             state_d = S_IDLE;
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)            state_d = S_EXEC;
                else if (opcode == OP_BEQ)              state_d = S_BRANCH;
                else if (opcode == OP_J)                state_d = S_JUMP;
                else begin
                    // Undecodable opcode: halt and latch the sticky flag.
                    state_d   = S_IDLE;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RCOMP;
            S_MEMWB, S_MEMWR, S_RCOMP, S_BRANCH, S_JUMP: begin
                // run is only honoured here, so mid-instruction changes wait.
                state_d = run ? S_FETCH : S_IDLE;
                done_d  = 1'b1;
            end
            // Codes 11-15 are unused; recover to IDLE.
            default:  state_d = S_IDLE;
        endcase
    end

    // State, done pulse and sticky illegal flag, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign current_state = state_q;
    assign instr_done    = done_q;
    assign illegal_op    = illegal_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    // Performance counters: active (non-IDLE) cycles and retired instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (done_q)            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_state_seq.sv
// Directed testbench for mc_state_seq. Counters are checked against a small
// bench-side model when MC_PERF_CNT_EN is defined, and against zero otherwise.
// The DUT uses CNT_W=4 so counter wrap is exercised.
module tb_mc_state_seq;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic             run;
    logic             step;
    logic [3:0]       current_state;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Counter model state: previous expected state/done, expected counts.
    logic [3:0]       prev_state = 4'd10;
    logic             prev_done  = 1'b0;
    logic [CNT_W-1:0] exp_cyc    = '0;
    logic [CNT_W-1:0] exp_ins    = '0;

    mc_state_seq #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .run           (run),
        .step          (step),
        .current_state (current_state),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, then check state, done pulse, illegal flag and counters.
    task automatic tick(input logic [3:0] es, input logic ed, input logic eil);
        if (rst) begin
            exp_cyc = '0;
            exp_ins = '0;
        end else begin
            if (prev_state != 4'd10) exp_cyc = exp_cyc + 1'b1;
            if (prev_done)           exp_ins = exp_ins + 1'b1;
        end
        @(posedge clk);
        #1;
        check("state", 32'(current_state), 32'(es));
        check("instr_done", 32'(instr_done), 32'(ed));
        check("illegal_op", 32'(illegal_op), 32'(eil));
`ifdef MC_PERF_CNT_EN
        check("cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
        check("instr_cnt", 32'(instr_cnt), 32'(exp_ins));
`else
        check("cycle_cnt_off", 32'(cycle_cnt), 32'd0);
        check("instr_cnt_off", 32'(instr_cnt), 32'd0);
`endif
        prev_state = es;
        prev_done  = ed;
    endtask

    initial begin
        rst    = 1'b1;
        run    = 1'b1;
        step   = 1'b0;
        opcode = 6'h23;

        // Reset held two cycles with run=1.
        tick(4'd10, 1'b0, 1'b0);
        tick(4'd10, 1'b0, 1'b0);
        rst = 1'b0;

        // lw back-to-back: 0,1,2,3,4 repeated, done after each 4.
        tick(4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick(4'd1, 1'b0, 1'b0);
            tick(4'd2, 1'b0, 1'b0);
            tick(4'd3, 1'b0, 1'b0);
            tick(4'd4, 1'b0, 1'b0);
            tick(4'd0, 1'b1, 1'b0);
        end
        // Drop run while in FETCH: current lw completes, then IDLE.
        run = 1'b0;
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd2, 1'b0, 1'b0);
        tick(4'd3, 1'b0, 1'b0);
        tick(4'd4, 1'b0, 1'b0);
        tick(4'd10, 1'b1, 1'b0);
        tick(4'd10, 1'b0, 1'b0);

        // Single-step beq.
        opcode = 6'h04;
        step   = 1'b1;
        tick(4'd0, 1'b0, 1'b0);
        step   = 1'b0;
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd8, 1'b0, 1'b0);
        tick(4'd10, 1'b1, 1'b0);
        tick(4'd10, 1'b0, 1'b0);
        tick(4'd10, 1'b0, 1'b0);

        // Single-step R-type.
        opcode = 6'h00;
        step   = 1'b1;
        tick(4'd0, 1'b0, 1'b0);
        step   = 1'b0;
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd6, 1'b0, 1'b0);
        tick(4'd7, 1'b0, 1'b0);
        tick(4'd10, 1'b1, 1'b0);
        tick(4'd10, 1'b0, 1'b0);

        // step held high re-launches j on each IDLE visit.
        opcode = 6'h02;
        step   = 1'b1;
        tick(4'd0, 1'b0, 1'b0);
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd9, 1'b0, 1'b0);
        tick(4'd10, 1'b1, 1'b0);
        tick(4'd0, 1'b0, 1'b0);
        step   = 1'b0;
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd9, 1'b0, 1'b0);
        tick(4'd10, 1'b1, 1'b0);

        // run drop in DECODE during j.
        run = 1'b1;
        tick(4'd0, 1'b0, 1'b0);
        tick(4'd1, 1'b0, 1'b0);
        run = 1'b0;
        tick(4'd9, 1'b0, 1'b0);
        tick(4'd10, 1'b1, 1'b0);

        // run drop in MEMADR during sw.
        opcode = 6'h2B;
        run    = 1'b1;
        tick(4'd0, 1'b0, 1'b0);
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd2, 1'b0, 1'b0);
        run    = 1'b0;
        tick(4'd5, 1'b0, 1'b0);
        tick(4'd10, 1'b1, 1'b0);

        // Illegal opcode: halts in IDLE with sticky flag despite run=1.
        opcode = 6'h3F;
        run    = 1'b1;
        tick(4'd0, 1'b0, 1'b0);
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd10, 1'b0, 1'b1);
        opcode = 6'h23;
        tick(4'd10, 1'b0, 1'b1);
        tick(4'd10, 1'b0, 1'b1);

        // Reset clears the flag; then reset in the middle of sw (state 5).
        rst = 1'b1;
        tick(4'd10, 1'b0, 1'b0);
        rst    = 1'b0;
        opcode = 6'h2B;
        tick(4'd0, 1'b0, 1'b0);
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd2, 1'b0, 1'b0);
        tick(4'd5, 1'b0, 1'b0);
        rst = 1'b1;
        tick(4'd10, 1'b0, 1'b0);
        rst = 1'b0;
        run = 1'b0;
        tick(4'd10, 1'b0, 1'b0);

        // Post-reset lw run of 17+ active cycles to wrap the 4-bit counter.
        run    = 1'b1;
        opcode = 6'h23;
        tick(4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(4'd1, 1'b0, 1'b0);
            tick(4'd2, 1'b0, 1'b0);
            tick(4'd3, 1'b0, 1'b0);
            tick(4'd4, 1'b0, 1'b0);
            tick(4'd0, 1'b1, 1'b0);
        end
`ifdef MC_PERF_CNT_EN
        // 20 active cycles completed (states 0..4 x4): 20 mod 16 = 4.
        check("cycle_wrap", 32'(cycle_cnt), 32'd4);
`else
        check("cycle_wrap_off", 32'(cycle_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
